// File: rtl/hf_conf_mode_switch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// hf_conf_mode_switch_pkg : command opcodes, major-mode indices, FSM states
// Rev 1.0
// ------------------------------------------------------------------------
package hf_conf_mode_switch_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG  = 4'h1;
  localparam logic [3:0] FPGA_CMD_TRACE_ENABLE = 4'h2;

  typedef enum logic [2:0] {
    MAJOR_HF_READER    = 3'd0,
    MAJOR_HF_SIMULATOR = 3'd1,
    MAJOR_HF_ISO14443A = 3'd2,
    MAJOR_HF_SNIFF     = 3'd3,
    MAJOR_HF_ISO18092  = 3'd4,
    MAJOR_HF_GET_TRACE = 3'd5,
    MAJOR_RESERVED     = 3'd6,
    MAJOR_OFF          = 3'd7
  } major_mode_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_GUARD = 1'b1
  } mode_state_e;

endpackage
`default_nettype wire

// File: rtl/hf_conf_mode_switch_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// hf_conf_mode_switch_if : ARM SPI lines (spck/mosi/ncs), ARM drives, FPGA listens
// Rev 1.0
// ------------------------------------------------------------------------
interface hf_conf_mode_switch_if;
  logic spck;
  logic mosi;
  logic ncs;

  modport master (output spck, output mosi, output ncs);
  modport slave  (input  spck, input  mosi, input  ncs);
endinterface
`default_nettype wire

// File: rtl/hf_conf_mode_switch_spi_cmd_rx.sv
`default_nettype none
// ------------------------------------------------------------------------
// hf_conf_mode_switch_spi_cmd_rx : oversampling SPI receiver with frame-length check
// Rev 1.0
// ------------------------------------------------------------------------
module hf_conf_mode_switch_spi_cmd_rx
  import hf_conf_mode_switch_pkg::*;
#(
  parameter int CMD_W = 16
) (
  input  wire logic              ck_1356meg,
  input  wire logic              nreset,
  hf_conf_mode_switch_if.slave   spi,
  output logic                   cmd_valid_o,
  output logic [CMD_W-1:0]       cmd_word_o,
  output logic                   frame_err_o
);

  localparam int CNT_W = $clog2(CMD_W + 2);

  // [0],[1] synchroniser stages, [2] history for edge detection
  logic [2:0]       spck_q;
  logic [2:0]       ncs_q;
  logic [1:0]       mosi_q;
  logic [CMD_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             err_q;

  logic w_spck_rise;
  logic w_ncs_low;
  logic w_ncs_fall;
  logic w_ncs_rise;

  assign w_spck_rise = spck_q[1] & ~spck_q[2];
  assign w_ncs_low   = ~ncs_q[1];
  assign w_ncs_fall  = ~ncs_q[1] &  ncs_q[2];
  assign w_ncs_rise  =  ncs_q[1] & ~ncs_q[2];

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      spck_q  <= '0;
      mosi_q  <= '0;
      ncs_q   <= '1;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      spck_q  <= {spck_q[1:0], spi.spck};
      mosi_q  <= {mosi_q[0], spi.mosi};
      ncs_q   <= {ncs_q[1:0], spi.ncs};
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (w_ncs_fall) begin
        cnt_q <= '0;
      end else if (w_spck_rise && w_ncs_low) begin
        shift_q <= {shift_q[CMD_W-2:0], mosi_q[1]};
        // Saturate one past a full word so over-long frames stay detectable
        if (cnt_q != CNT_W'(CMD_W + 1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (w_ncs_rise) begin
        if (cnt_q == CNT_W'(CMD_W)) begin
          valid_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_word_o  = shift_q;
  assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/hf_conf_mode_switch.sv
`default_nettype none
// ------------------------------------------------------------------------
// hf_conf_mode_switch : HF config register decode and guarded major-mode output mux
// Rev 1.0
// ------------------------------------------------------------------------
module hf_conf_mode_switch
  import hf_conf_mode_switch_pkg::*;
#(
  parameter int               CMD_W        = 16,
  parameter int               OPC_W        = 4,
  parameter int               CONF_W       = 9,
  parameter int               MODE_W       = 3,
  parameter int               NUM_MODES    = 8,
  parameter int               OUT_W        = 11,
  parameter int               GUARD_CYCLES = 4,
  parameter logic [OUT_W-1:0] SAFE_VAL     = '0
) (
  input  wire logic                   ck_1356meg,
  input  wire logic                   nreset,
  hf_conf_mode_switch_if.slave        spi,
  input  wire logic [NUM_MODES*OUT_W-1:0] mode_bus,
  output logic [OUT_W-1:0]            y,
  output logic [CONF_W-1:0]           conf_word,
  output logic [MODE_W-1:0]           major_mode,
  output logic [3:0]                  minor_mode,
  output logic [1:0]                  subcarrier_frequency,
  output logic                        trace_enable,
  output logic                        switching,
  output logic                        frame_err
);

  logic              w_cmd_valid;
  logic [CMD_W-1:0]  w_cmd_word;
  logic              w_frame_err;
  logic [OPC_W-1:0]  w_opcode;
  logic [MODE_W-1:0] w_mode_field;
  logic [OUT_W-1:0]  w_run_bundle;
  logic [OUT_W-1:0]  w_new_bundle;
  logic              w_unused_cmd_bits;

  mode_state_e       state_q;
  logic [7:0]        guard_q;
  logic [MODE_W-1:0] major_q;
  logic [MODE_W-1:0] target_q;
  logic [OUT_W-1:0]  y_q;
  logic              sw_q;
  logic [CONF_W-1:0] conf_q;
  logic              trace_q;
  logic              ferr_q;

  hf_conf_mode_switch_spi_cmd_rx #(
    .CMD_W (CMD_W)
  ) u_rx (
    .ck_1356meg  (ck_1356meg),
    .nreset      (nreset),
    .spi         (spi),
    .cmd_valid_o (w_cmd_valid),
    .cmd_word_o  (w_cmd_word),
    .frame_err_o (w_frame_err)
  );

  assign w_opcode          = w_cmd_word[CMD_W-1 -: OPC_W];
  assign w_mode_field      = conf_q[CONF_W-1 -: MODE_W];
  assign w_unused_cmd_bits = &{1'b0, w_cmd_word[CMD_W-OPC_W-1:CONF_W]};

  // Unpopulated mode indices fall back to the safe bundle
  always_comb begin
    w_run_bundle = SAFE_VAL;
    w_new_bundle = SAFE_VAL;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (major_q == MODE_W'(k)) w_run_bundle = mode_bus[k*OUT_W +: OUT_W];
      if (target_q == MODE_W'(k)) w_new_bundle = mode_bus[k*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_RUN;
      guard_q  <= '0;
      major_q  <= '1;
      target_q <= '1;
      y_q      <= SAFE_VAL;
      sw_q     <= 1'b0;
      conf_q   <= {{MODE_W{1'b1}}, {(CONF_W-MODE_W){1'b0}}};
      trace_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ferr_q <= w_frame_err;
      if (w_cmd_valid) begin
        if (w_opcode == OPC_W'(FPGA_CMD_SET_CONFREG)) begin
          conf_q <= w_cmd_word[CONF_W-1:0];
        end else if (w_opcode == OPC_W'(FPGA_CMD_TRACE_ENABLE)) begin
          trace_q <= w_cmd_word[0];
        end
      end

      case (state_q)
        ST_RUN: begin
          if (w_mode_field != major_q) begin
            state_q  <= ST_GUARD;
            guard_q  <= 8'(GUARD_CYCLES - 1);
            target_q <= w_mode_field;
            sw_q     <= 1'b1;
            y_q      <= SAFE_VAL;
          end else begin
            y_q <= w_run_bundle;
          end
        end
        ST_GUARD: begin
          y_q <= SAFE_VAL;
          if (w_mode_field != target_q) begin
            guard_q  <= 8'(GUARD_CYCLES - 1);
            target_q <= w_mode_field;
          end else if (guard_q == '0) begin
            // Last safe cycle: hand over directly so the gap is exactly GUARD_CYCLES
            major_q <= target_q;
            sw_q    <= 1'b0;
            state_q <= ST_RUN;
            y_q     <= w_new_bundle;
          end else begin
            guard_q <= guard_q - 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign y                    = y_q;
  assign conf_word            = conf_q;
  assign major_mode           = major_q;
  assign minor_mode           = conf_q[3:0];
  assign subcarrier_frequency = conf_q[5:4];
  assign trace_enable         = trace_q;
  assign switching            = sw_q;
  assign frame_err            = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_hf_conf_mode_switch.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_hf_conf_mode_switch : directed + random SPI frames against a timeline reference model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_hf_conf_mode_switch;
  import hf_conf_mode_switch_pkg::*;

  localparam int NM = 6;
  localparam int OW = 11;
  localparam int G  = 80;

  logic              ck = 1'b0;
  logic              nreset = 1'b0;
  logic [NM*OW-1:0]  mode_bus;
  logic [OW-1:0]     y;
  logic [8:0]        conf_word;
  logic [2:0]        major_mode;
  logic [3:0]        minor_mode;
  logic [1:0]        subc;
  logic              trace_enable, switching, frame_err;

  hf_conf_mode_switch_if spi_if ();

  hf_conf_mode_switch #(.NUM_MODES(NM), .GUARD_CYCLES(G)) dut (
    .ck_1356meg           (ck),
    .nreset               (nreset),
    .spi                  (spi_if),
    .mode_bus             (mode_bus),
    .y                    (y),
    .conf_word            (conf_word),
    .major_mode           (major_mode),
    .minor_mode           (minor_mode),
    .subcarrier_frequency (subc),
    .trace_enable         (trace_enable),
    .switching            (switching),
    .frame_err            (frame_err)
  );

  always #5 ck = ~ck;

  typedef struct {
    int         t;
    bit         err;
    bit         has_conf;
    logic [8:0] conf;
    bit         has_tr;
    bit         tr;
  } ev_t;

  ev_t         evq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [OW-1:0] bundle [8];

  // Reference state: what the spec says is in effect after each clock edge
  logic [8:0]  m_conf;
  logic        m_trace;
  logic [2:0]  m_active, m_target;
  bit          m_pending;
  int          m_start, m_deadline, m_ferr_t;

  always @(posedge ck) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_conf = 9'h1C0; m_trace = 1'b0; m_active = 3'd7; m_target = 3'd7;
    m_pending = 1'b0; m_start = 0; m_deadline = 0; m_ferr_t = -1;
    evq.delete();
  endfunction

  always @(negedge ck) begin : monitor
    ev_t        e;
    logic [2:0] req;
    bit         exp_sw;
    if (!nreset) begin
      model_reset();
      check("rst_y", y, 0);
      check("rst_major", major_mode, 7);
      check("rst_conf", conf_word, 9'h1C0);
      check("rst_trace", trace_enable, 0);
      check("rst_switching", switching, 0);
      check("rst_frame_err", frame_err, 0);
    end else begin
      if (m_pending && cyc >= m_deadline) begin
        m_active  = m_target;
        m_pending = 1'b0;
      end
      while (evq.size() > 0 && evq[0].t <= cyc) begin
        e = evq.pop_front();
        if (e.err) m_ferr_t = cyc;
        if (e.has_tr) m_trace = e.tr;
        if (e.has_conf) begin
          m_conf = e.conf;
          req = m_pending ? m_target : m_active;
          if (e.conf[8:6] != req) begin
            if (!m_pending) m_start = cyc + 1;
            m_pending  = 1'b1;
            m_target   = e.conf[8:6];
            m_deadline = cyc + 1 + G;
          end
        end
      end
      exp_sw = m_pending && (cyc >= m_start);
      check("y", y, exp_sw ? '0 : bundle[m_active]);
      check("switching", switching, exp_sw);
      check("major_mode", major_mode, m_active);
      check("conf_word", conf_word, m_conf);
      check("minor_mode", minor_mode, m_conf[3:0]);
      check("subcarrier", subc, m_conf[5:4]);
      check("trace_enable", trace_enable, m_trace);
      check("frame_err", frame_err, cyc == m_ferr_t);
    end
  end

  task automatic spi_bit(input logic b);
    spi_if.mosi = b;
    repeat (2) @(negedge ck);
    spi_if.spck = 1'b1;
    repeat (2) @(negedge ck);
    spi_if.spck = 1'b0;
  endtask

  // Sends the low n bits of v MSB first and records the expected decode 4 cycles after ncs rises
  task automatic send_frame(input logic [31:0] v, input int n);
    ev_t e;
    spi_if.ncs = 1'b0;
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    repeat (2) @(negedge ck);
    spi_if.ncs = 1'b1;
    e = '{default: 0};
    e.t = cyc + 4;
    if (n == 16) begin
      if (v[15:12] == FPGA_CMD_SET_CONFREG) begin
        e.has_conf = 1'b1; e.conf = v[8:0];
      end else if (v[15:12] == FPGA_CMD_TRACE_ENABLE) begin
        e.has_tr = 1'b1; e.tr = v[0];
      end
    end else begin
      e.err = 1'b1;
    end
    if (e.err || e.has_conf || e.has_tr) evq.push_back(e);
    repeat (6) @(negedge ck);
  endtask

  initial begin
    logic [31:0] v;
    int          kind;
    logic [3:0]  opc;
    model_reset();
    spi_if.ncs = 1'b1; spi_if.spck = 1'b0; spi_if.mosi = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bundle[k] = (k < NM) ? (OW'($urandom) & 11'h3F8) | 11'h400 | OW'(k) : '0;
    end
    for (int k = 0; k < NM; k++) mode_bus[k*OW +: OW] = bundle[k];
    repeat (3) @(negedge ck);
    nreset = 1'b1;
    repeat (3) @(negedge ck);

    send_frame(32'h1041, 16);
    repeat (G + 10) @(negedge ck);
    check("cfg_major", major_mode, 3'd1);
    check("cfg_y", y, bundle[1]);
    check("cfg_minor", minor_mode, 4'd1);

    send_frame(32'h1082, 15);
    send_frame(32'h11082, 17);
    check("bad_len_conf", conf_word, 9'h041);

    send_frame(32'h2001, 16);
    check("trace_on", trace_enable, 1'b1);
    send_frame(32'h2000, 16);
    check("trace_off", trace_enable, 1'b0);
    check("trace_no_guard", switching, 1'b0);

    // Second write lands inside the first guard interval
    send_frame(32'h1081, 16);
    send_frame(32'h1101, 16);
    check("b2b_switching", switching, 1'b1);
    repeat (G + 10) @(negedge ck);
    check("b2b_major", major_mode, 3'd4);
    check("b2b_y", y, bundle[4]);

    send_frame(32'h1181, 16);
    repeat (G + 10) @(negedge ck);
    check("unused_mode_major", major_mode, 3'd6);
    check("unused_mode_y", y, 0);

    send_frame(32'h1041, 16);
    repeat (10) @(negedge ck);
    #2 nreset = 1'b0;
    #1;
    check("async_rst_y", y, 0);
    check("async_rst_major", major_mode, 3'd7);
    check("async_rst_conf", conf_word, 9'h1C0);
    check("async_rst_switching", switching, 1'b0);
    repeat (3) @(negedge ck);
    nreset = 1'b1;
    repeat (3) @(negedge ck);

    spi_if.ncs = 1'b0;
    for (int i = 0; i < 8; i++) spi_bit(i[0]);
    nreset = 1'b0;
    spi_if.ncs = 1'b1;
    repeat (3) @(negedge ck);
    nreset = 1'b1;
    repeat (3) @(negedge ck);
    send_frame(32'h2001, 16);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: begin
          v = {16'h0, FPGA_CMD_SET_CONFREG, 3'($urandom), 3'($urandom_range(0, 7)), 6'($urandom)};
          send_frame(v, 16);
        end
        2: send_frame({16'h0, FPGA_CMD_TRACE_ENABLE, 12'($urandom)}, 16);
        3: send_frame($urandom, $urandom_range(1, 15));
        4: send_frame($urandom, $urandom_range(17, 20));
        default: begin
          opc = 4'($urandom_range(3, 16) % 16);
          send_frame({16'h0, opc, 12'($urandom)}, 16);
        end
      endcase
      repeat ($urandom_range(0, 120)) @(negedge ck);
    end
    repeat (G + 10) @(negedge ck);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
